// File: rtl/z480_wb_arbiter.sv
// ---------------------------------------------------------------------------
// z480_pkg / z480_wb_arbiter
//
// Purpose
//   Round-robin arbiter that shares the single ROB writeback port between
//   N_PORTS execution units. Every cycle it grants at most one requester,
//   scanning from rr_ptr. The winning payload goes into a 1-entry output
//   register that drives the ROB completion port. A core-wide flush kills
//   the held entry and blocks acceptance for that cycle.
//
// Ports
//   clk        in   1                    core clock
//   rst_n      in   1                    synchronous active-low reset
//   flush      in   1                    pipeline flush
//   in_valid   in   N_PORTS              per-unit writeback valid
//   in_wb      in   N_PORTS x z480_wb_t  per-unit writeback payload
//   in_ready   out  N_PORTS              per-unit ready (one-hot or zero)
//   out_valid  out  1                    writeback to ROB valid
//   out_wb     out  z480_wb_t            registered winning payload
//   out_src    out  SRC_W                index of the unit that produced out_wb
//   out_ready  in   1                    ROB accepts writeback
// ---------------------------------------------------------------------------

package z480_pkg;

    // Writeback record that the execution units hand to the ROB.
    typedef struct packed {
        logic [5:0]  rob_idx;
        logic [31:0] data;
        logic        exc;
    } z480_wb_t;

endpackage

module z480_wb_arbiter #(
    parameter  int N_PORTS = 4,
    localparam int SRC_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic             [N_PORTS-1:0]       in_valid,
    input  z480_pkg::z480_wb_t [N_PORTS-1:0]     in_wb,
    output logic             [N_PORTS-1:0]       in_ready,
    output logic                                 out_valid,
    output z480_pkg::z480_wb_t                   out_wb,
    output logic             [SRC_W-1:0]         out_src,
    input  logic                                 out_ready
);

    logic                 r_out_valid;
    z480_pkg::z480_wb_t   r_out_wb;
    logic [SRC_W-1:0]     r_out_src;
    logic [SRC_W-1:0]     r_rr_ptr;

    logic [N_PORTS-1:0]   w_grant;
    logic [SRC_W-1:0]     w_gnt_idx;
    logic                 w_found;
    logic                 w_slot_free;
    logic                 w_open;
    logic                 w_accept;
    logic [SRC_W-1:0]     w_ptr_next;

    // Rotating priority split into two linear scans: first the ports at or
    // above rr_ptr, then (only if none of those requests) the ports below it.
    // This gives the same winner as a modulo scan without a wide rotated index.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (!w_found && in_valid[SRC_W'(i)] && (SRC_W'(i) >= r_rr_ptr)) begin
                w_found   = 1'b1;
                w_gnt_idx = SRC_W'(i);
            end
        end
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (!w_found && in_valid[SRC_W'(i)]) begin
                w_found   = 1'b1;
                w_gnt_idx = SRC_W'(i);
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_found) begin
            w_grant[w_gnt_idx] = 1'b1;
        end
    end

    // Ready is withheld while reset is asserted so no producer believes a
    // payload was taken that the reset is about to drop.
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_open      = w_slot_free && !flush && rst_n;
    assign in_ready    = w_grant & {N_PORTS{w_open}};
    assign w_accept    = |(in_valid & in_ready);

    assign w_ptr_next  = (w_gnt_idx == SRC_W'(N_PORTS - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_wb    <= '0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_wb    <= in_wb[w_gnt_idx];
            r_out_src   <= w_gnt_idx;
            r_rr_ptr    <= w_ptr_next;
        end else if (flush || out_ready) begin
            // Retire or flush with nothing new: drop valid, keep payload/src.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_wb    = r_out_wb;
    assign out_src   = r_out_src;

    a_ready_onehot0 : assert property (@(posedge clk) $onehot0(in_ready));

    a_hold_stable : assert property (@(posedge clk)
        (rst_n && out_valid && !out_ready) |=> ($stable(out_wb) && $stable(out_src)));

endmodule

// File: tb/tb_z480_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_z480_wb_arbiter
//
// Purpose
//   Drives a 4-port and a 3-port arbiter. Directed sequences cover reset,
//   round-robin order, backpressure, flush, wrap/skip and reset mid-stream
//   with hand-computed expectations; a randomized phase follows. A monitor
//   compares every output of both instances, every cycle, against a
//   behavioural model (first valid port scanning from the pointer).
// ---------------------------------------------------------------------------

module tb_z480_wb_arbiter;
    import z480_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 flush;

    logic [3:0]           v4;
    z480_wb_t [3:0]       wb4;
    logic [3:0]           rdy4;
    logic                 ov4;
    z480_wb_t             owb4;
    logic [1:0]           osrc4;
    logic                 ordy4;

    logic [2:0]           v3;
    z480_wb_t [2:0]       wb3;
    logic [2:0]           rdy3;
    logic                 ov3;
    z480_wb_t             owb3;
    logic [1:0]           osrc3;
    logic                 ordy3;

    z480_wb_arbiter #(.N_PORTS(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (v4),
        .in_wb     (wb4),
        .in_ready  (rdy4),
        .out_valid (ov4),
        .out_wb    (owb4),
        .out_src   (osrc4),
        .out_ready (ordy4)
    );

    z480_wb_arbiter #(.N_PORTS(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (v3),
        .in_wb     (wb3),
        .in_ready  (rdy3),
        .out_valid (ov3),
        .out_wb    (owb3),
        .out_src   (osrc3),
        .out_ready (ordy3)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit       v;
        z480_wb_t wb;
        int       src;
        int       ptr;
    } mstate_t;

    mstate_t m4;
    mstate_t m3;

    function automatic int pick(input int n, input int ptr, input logic [15:0] vld);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (ptr + k) % n;
            if (vld[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset(output mstate_t m);
        m.v   = 1'b0;
        m.wb  = '0;
        m.src = 0;
        m.ptr = 0;
    endtask

    task automatic model_step(input string tag, input int n, inout mstate_t m,
                              input logic rst, input logic fl, input logic [15:0] vld,
                              input z480_wb_t ins [16], input logic ordy,
                              input logic ov, input z480_wb_t owb, input int osrc,
                              input logic [15:0] rdy);
        int          g;
        bit          slot;
        logic [15:0] er;
        chk({tag, ".out_valid"}, 64'(ov), 64'(m.v));
        chk({tag, ".out_wb"},    64'(owb), 64'(m.wb));
        chk({tag, ".out_src"},   64'(osrc), 64'(m.src));
        g    = pick(n, m.ptr, vld);
        slot = !m.v || ordy;
        er   = '0;
        if (rst && !fl && slot && g >= 0) er[g] = 1'b1;
        chk({tag, ".in_ready"}, 64'(rdy), 64'(er));
        if (!rst) begin
            model_reset(m);
        end else if (er != 0) begin
            m.v   = 1'b1;
            m.wb  = ins[g];
            m.src = g;
            m.ptr = (g + 1) % n;
        end else if (fl || ordy) begin
            m.v = 1'b0;
        end
    endtask

    initial begin : monitor
        z480_wb_t a4 [16];
        z480_wb_t a3 [16];
        model_reset(m4);
        model_reset(m3);
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int i = 0; i < 16; i++) begin
                a4[i] = (i < 4) ? wb4[i] : '0;
                a3[i] = (i < 3) ? wb3[i] : '0;
            end
            model_step("m4", 4, m4, rst_n, flush, {12'b0, v4}, a4, ordy4,
                       ov4, owb4, int'(osrc4), {12'b0, rdy4});
            model_step("m3", 3, m3, rst_n, flush, {13'b0, v3}, a3, ordy3,
                       ov3, owb3, int'(osrc3), {13'b0, rdy3});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic z480_wb_t rand_wb();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[$bits(z480_wb_t)-1:0];
    endfunction

    initial begin : stim
        int exp_src [4];
        exp_src = '{2, 0, 2, 0};

        rst_n = 1'b0;
        flush = 1'b0;
        v4    = 4'hF;
        ordy4 = 1'b1;
        v3    = 3'b000;
        ordy3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wb4[i].rob_idx = 6'(i);
            wb4[i].data    = 32'hA000 + 32'(i);
            wb4[i].exc     = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            wb3[i].rob_idx = 6'(10 + i);
            wb3[i].data    = 32'hB000 + 32'(i);
            wb3[i].exc     = 1'b1;
        end

        // Reset held for two edges with all ports requesting
        @(negedge clk);
        chk("rst.out_valid", 64'(ov4), 64'd0);
        chk("rst.in_ready",  64'(rdy4), 64'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.first_grant", 64'(rdy4), 64'b0001);
        chk("rst.out_valid2",  64'(ov4), 64'd0);

        // Round-robin: 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            chk("rr.out_valid", 64'(ov4), 64'd1);
            chk("rr.out_src",   64'(osrc4), 64'(k % 4));
            chk("rr.rob_idx",   64'(owb4.rob_idx), 64'(k % 4));
        end

        // Backpressure: port 1 gets taken, then ROB stalls for 3 cycles
        step();
        ordy4 = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("bp.in_ready",  64'(rdy4), 64'd0);
            chk("bp.out_valid", 64'(ov4), 64'd1);
            chk("bp.out_src",   64'(osrc4), 64'd1);
            chk("bp.rob_idx",   64'(owb4.rob_idx), 64'd1);
            step();
        end
        ordy4 = 1'b1;
        @(negedge clk);
        chk("bp.release_grant", 64'(rdy4), 64'b0100);
        step();
        v4 = 4'b0010;
        @(negedge clk);
        chk("bp.after_src", 64'(osrc4), 64'd2);
        chk("bp.skip_grant", 64'(rdy4), 64'b0010);

        // Flush with src 1 held and ports 2,3 requesting
        step();
        v4    = 4'b1100;
        flush = 1'b1;
        @(negedge clk);
        chk("fl.pre_src",  64'(osrc4), 64'd1);
        chk("fl.in_ready", 64'(rdy4), 64'd0);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("fl.out_valid", 64'(ov4), 64'd0);
        chk("fl.src_held",  64'(osrc4), 64'd1);
        chk("fl.next_grant", 64'(rdy4), 64'b0100);
        step();
        @(negedge clk);
        chk("fl.out_src",  64'(osrc4), 64'd2);
        chk("fl.valid",    64'(ov4), 64'd1);

        // Reset mid-stream while the ROB is stalled
        step();
        ordy4 = 1'b0;
        v4    = 4'hF;
        @(negedge clk);
        chk("rm.held_valid", 64'(ov4), 64'd1);
        chk("rm.held_src",   64'(osrc4), 64'd3);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rm.rdy_in_reset", 64'(rdy4), 64'd0);
        step();
        rst_n = 1'b1;
        ordy4 = 1'b1;
        @(negedge clk);
        chk("rm.out_valid", 64'(ov4), 64'd0);
        chk("rm.out_wb",    64'(owb4), 64'd0);
        chk("rm.out_src",   64'(osrc4), 64'd0);
        chk("rm.grant0",    64'(rdy4), 64'b0001);
        step();
        v4 = 4'b0000;
        @(negedge clk);
        chk("rm.first_src", 64'(osrc4), 64'd0);

        // Wrap/skip on the 3-port instance: move rr_ptr to 1, then 2,0,2,0
        step();
        v3 = 3'b001;
        @(negedge clk);
        chk("ws.grant0", 64'(rdy3), 64'b001);
        step();
        v3 = 3'b101;
        @(negedge clk);
        chk("ws.src0",  64'(osrc3), 64'd0);
        chk("ws.first", 64'(rdy3), 64'b100);
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            chk("ws.out_src", 64'(osrc3), 64'(exp_src[k]));
            chk("ws.rob_idx", 64'(owb3.rob_idx), 64'(10 + exp_src[k]));
            chk("ws.next",    64'(rdy3), (exp_src[k] == 2) ? 64'b001 : 64'b100);
        end

        // Randomized phase, checked by the monitor
        for (int c = 0; c < 3000; c++) begin
            step();
            v4    = 4'($urandom);
            v3    = 3'($urandom);
            for (int i = 0; i < 4; i++) wb4[i] = rand_wb();
            for (int i = 0; i < 3; i++) wb3[i] = rand_wb();
            ordy4 = ($urandom_range(0, 9) < 7);
            ordy3 = ($urandom_range(0, 9) < 5);
            flush = ($urandom_range(0, 19) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
        end
        step();
        @(negedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
